// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results to writeback or performs one LW/SW data-memory access.
// Optional MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYC cycles without mem_ack and sets sticky err.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [5:0]  opcode,
    input  logic [31:0] alu_res,
    input  logic [31:0] store_data,
    input  logic [4:0]  dest_reg,
    output logic        in_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        err
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned OW = 6;

    localparam logic [OW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OW-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OW-1:0] OP_LW    = 6'b100011;
    localparam logic [OW-1:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WB     = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          is_mem_c, writes_c, timeout_c;
    logic          mem_we_nxt, wb_we_nxt;
    logic [DW-1:0] mem_addr_nxt, mem_wdata_nxt, wb_data_nxt;
    logic [RW-1:0] wb_reg_nxt;

    assign is_mem_c = (opcode == OP_LW) || (opcode == OP_SW);
    assign writes_c = (opcode == OP_RTYPE) || (opcode == OP_ADDI) || (opcode == OP_ANDI);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] tmo_cnt;

    // Limit reached on this edge without ack; an ack on the same edge takes priority.
    assign timeout_c = (state == S_ACCESS) && !mem_ack
                       && ((32'(tmo_cnt) + 32'd1) >= TIMEOUT_CYC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state == S_ACCESS && !mem_ack && !timeout_c) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end else begin
                tmo_cnt <= '0;
            end
            if (timeout_c) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign timeout_c = 1'b0;
    assign err       = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_reg    <= '0;
            wb_data   <= '0;
        end else begin
            state     <= state_nxt;
            mem_req   <= (state_nxt == S_ACCESS);
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            wb_valid  <= (state_nxt == S_WB);
            wb_we     <= wb_we_nxt;
            wb_reg    <= wb_reg_nxt;
            wb_data   <= wb_data_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (in_valid) state_nxt = is_mem_c ? S_ACCESS : S_WB;
            S_ACCESS: if (mem_ack || timeout_c) state_nxt = S_WB;
            S_WB:     state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values; wb_we self-clears outside the WB cycle
    always_comb begin
        in_ready      = (state == S_IDLE);
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        wb_reg_nxt    = wb_reg;
        wb_data_nxt   = wb_data;
        wb_we_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    wb_reg_nxt = dest_reg;
                    if (is_mem_c) begin
                        mem_addr_nxt  = {alu_res[DW-1:2], 2'b00};
                        mem_wdata_nxt = store_data;
                        mem_we_nxt    = (opcode == OP_SW);
                    end else begin
                        wb_data_nxt = alu_res;
                        wb_we_nxt   = writes_c && (dest_reg != '0);
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ack && !mem_we) begin
                    wb_data_nxt = mem_rdata;
                    wb_we_nxt   = (wb_reg != '0);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model. Define MEM_TIMEOUT_EN to also exercise the timeout.
module tb_mem_stage;

    localparam int TMO = 4;
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ADDI= 6'b001000;
    localparam logic [5:0] OP_ANDI= 6'b001100;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;

    logic        clk, rst_n, in_valid, in_ready;
    logic [5:0]  opcode;
    logic [31:0] alu_res, store_data, mem_addr, mem_wdata, mem_rdata, wb_data;
    logic [4:0]  dest_reg, wb_reg;
    logic        mem_req, mem_we, mem_ack, wb_valid, wb_we, err;

    int checks = 0;
    int errors = 0;

    mem_stage #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode),
        .alu_res(alu_res), .store_data(store_data), .dest_reg(dest_reg),
        .in_ready(in_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_we(wb_we),
        .wb_reg(wb_reg), .wb_data(wb_data), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // 2 = memory op, 1 = register write, 0 = no write
    function automatic int kind(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:          return 2;
            OP_R, OP_ADDI, OP_ANDI: return 1;
            default:               return 0;
        endcase
    endfunction

    // Transaction-level model: one outstanding op, either a memory access in flight or a writeback slot
    bit          m_mem, m_wb, m_err, m_we, m_wbwe, m_data_ok;
    int          m_waited;
    logic [31:0] m_addr, m_wdata, m_data;
    logic [4:0]  m_reg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mem = 0; m_wb = 0; m_err = 0; m_waited = 0;
        end else if (m_wb) begin
            m_wb = 0;
        end else if (m_mem) begin
            if (mem_ack) begin
                m_mem = 0; m_wb = 1;
                m_wbwe = !m_we && (m_reg != 0);
                m_data_ok = !m_we;
                if (!m_we) m_data = mem_rdata;
            end else begin
                m_waited++;
`ifdef MEM_TIMEOUT_EN
                if (m_waited >= TMO) begin
                    m_mem = 0; m_wb = 1; m_wbwe = 0; m_data_ok = 0; m_err = 1;
                end
`endif
            end
        end else if (in_valid) begin
            m_reg = dest_reg;
            if (kind(opcode) == 2) begin
                m_mem = 1; m_waited = 0;
                m_addr = alu_res & 32'hFFFF_FFFC;
                m_wdata = store_data;
                m_we = (opcode == OP_SW);
            end else begin
                m_wb = 1; m_data = alu_res; m_data_ok = 1;
                m_wbwe = (kind(opcode) == 1) && (dest_reg != 0);
            end
        end
    end

    // Every-cycle comparison against the model (or reset values while reset is held)
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst in_ready", 32'(in_ready), 32'd1);
            chk("rst mem_req", 32'(mem_req), 32'd0);
            chk("rst mem_we", 32'(mem_we), 32'd0);
            chk("rst mem_addr", mem_addr, 32'd0);
            chk("rst mem_wdata", mem_wdata, 32'd0);
            chk("rst wb_valid", 32'(wb_valid), 32'd0);
            chk("rst wb_we", 32'(wb_we), 32'd0);
            chk("rst wb_reg", 32'(wb_reg), 32'd0);
            chk("rst wb_data", wb_data, 32'd0);
            chk("rst err", 32'(err), 32'd0);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!(m_mem || m_wb)));
            chk("mem_req", 32'(mem_req), 32'(m_mem));
            chk("wb_valid", 32'(wb_valid), 32'(m_wb));
            chk("err", 32'(err), 32'(m_err));
            if (m_mem) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we", 32'(mem_we), 32'(m_we));
                chk("mem_wdata", mem_wdata, m_wdata);
            end
            if (m_wb) begin
                chk("wb_reg", 32'(wb_reg), 32'(m_reg));
                chk("wb_we", 32'(wb_we), 32'(m_wbwe));
                if (m_data_ok) chk("wb_data", wb_data, m_data);
            end
        end
    end

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] d);
        in_valid = v; opcode = op; alu_res = a; store_data = sd; dest_reg = d;
    endtask

    // Count request cycles, asserting ack during request cycle ack_at (0 = never), bounded
    task automatic mem_wait(input int ack_at, input logic [31:0] rdata, output int n);
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            mem_ack = (n == ack_at);
            mem_rdata = rdata;
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    int nreq;

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        drive(0, OP_R, 0, 0, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // ADD to r3
        @(negedge clk); drive(1, OP_R, 32'h7, 0, 5'd3);
        @(negedge clk); drive(0, OP_R, 0, 0, 0);
        chk("add wb_valid", 32'(wb_valid), 32'd1);
        chk("add wb_we", 32'(wb_we), 32'd1);
        chk("add wb_reg", 32'(wb_reg), 32'd3);
        chk("add wb_data", wb_data, 32'd7);
        chk("add in_ready busy", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("add in_ready back", 32'(in_ready), 32'd1);

        // LW with ack in the third request cycle
        drive(1, OP_LW, 32'h103, 32'h0, 5'd5);
        @(negedge clk); drive(0, OP_R, 0, 0, 0);
        chk("lw mem_addr", mem_addr, 32'h100);
        chk("lw mem_we", 32'(mem_we), 32'd0);
        mem_wait(3, 32'hDEAD_BEEF, nreq);
        chk("lw req cycles", 32'(nreq), 32'd3);
        chk("lw wb_valid", 32'(wb_valid), 32'd1);
        chk("lw wb_data", wb_data, 32'hDEAD_BEEF);
        chk("lw wb_we", 32'(wb_we), 32'd1);
        @(negedge clk);

        // SW with immediate ack
        drive(1, OP_SW, 32'h40, 32'h1234, 5'd7);
        @(negedge clk); drive(0, OP_R, 0, 0, 0);
        chk("sw mem_we", 32'(mem_we), 32'd1);
        chk("sw mem_wdata", mem_wdata, 32'h1234);
        chk("sw mem_addr", mem_addr, 32'h40);
        mem_wait(1, 32'h0, nreq);
        chk("sw req cycles", 32'(nreq), 32'd1);
        chk("sw wb_valid", 32'(wb_valid), 32'd1);
        chk("sw wb_we", 32'(wb_we), 32'd0);
        @(negedge clk);

        // ADDI to $0, then BEQ held through the WB cycle
        drive(1, OP_ADDI, 32'h5, 0, 5'd0);
        @(negedge clk); drive(1, OP_BEQ, 32'h99, 0, 5'd4);
        chk("r0 wb_valid", 32'(wb_valid), 32'd1);
        chk("r0 wb_we", 32'(wb_we), 32'd0);
        @(negedge clk);
        chk("beq ignored in wb", 32'(wb_valid), 32'd0);
        chk("beq in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); drive(0, OP_R, 0, 0, 0);
        chk("beq wb_valid", 32'(wb_valid), 32'd1);
        chk("beq wb_we", 32'(wb_we), 32'd0);
        chk("beq wb_data", wb_data, 32'h99);
        @(negedge clk);

`ifdef MEM_TIMEOUT_EN
        drive(1, OP_LW, 32'h200, 0, 5'd6);
        @(negedge clk); drive(0, OP_R, 0, 0, 0);
        mem_wait(0, 32'h0, nreq);
        chk("tmo req cycles", 32'(nreq), 32'(TMO));
        chk("tmo wb_valid", 32'(wb_valid), 32'd1);
        chk("tmo wb_we", 32'(wb_we), 32'd0);
        chk("tmo err", 32'(err), 32'd1);
        @(negedge clk); @(negedge clk);
        chk("tmo err sticky", 32'(err), 32'd1);
`endif

        // Reset asserted mid-access
        drive(1, OP_LW, 32'h300, 0, 5'd8);
        @(negedge clk); drive(0, OP_R, 0, 0, 0);
        chk("rst lw mem_req", 32'(mem_req), 32'd1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 chk("async mem_req", 32'(mem_req), 32'd0);
        chk("async wb_valid", 32'(wb_valid), 32'd0);
        chk("async err", 32'(err), 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        drive(1, OP_R, 32'h55, 0, 5'd9);
        @(negedge clk); drive(0, OP_R, 0, 0, 0);
        chk("post rst wb_valid", 32'(wb_valid), 32'd1);
        chk("post rst wb_data", wb_data, 32'h55);

        // Randomized traffic, including acks outside ACCESS
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] ops [10];
            ops = '{OP_R, OP_ADDI, OP_ANDI, OP_BEQ, OP_BNE, OP_J, OP_LW, OP_SW, OP_LW, 6'h3F};
            @(negedge clk);
            in_valid   = ($urandom_range(0, 3) != 0);
            opcode     = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            alu_res    = $urandom;
            store_data = $urandom;
            dest_reg   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            mem_ack    = ($urandom_range(0, 2) == 0);
            mem_rdata  = $urandom;
        end
        @(negedge clk);
        drive(0, OP_R, 0, 0, 0);
        mem_ack = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
